fcb_uart_rx: RTL and testbench

FCB_UART_RX -- requirements
Module: fcb_uart_rx

---
 rtl/fcb_uart_rx.sv | 130 +++++++++++++
 tb/tb_fcb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcb_uart_rx.sv
// UART receiver: 2-flop line synchronizer, start/data/stop FSM driven by an external
// mid-bit baud strobe, a single-entry holding register and sticky error flags.
module fcb_uart_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 Bus_Clk_i,
  input  logic                 RST_i,
  input  logic                 Rx_i,
  input  logic                 Baud_rate_re_i,
  output logic                 Clear_br_cnt_o,
  output logic [DATA_BITS-1:0] Rx_Data_o,
  output logic                 Rx_Valid_o,
  input  logic                 Rx_Ack_i,
  output logic                 Frame_Err_o,
  output logic                 Overrun_o,
  input  logic                 Err_Clr_i,
  output logic                 Rx_Busy_o
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [2:0] LastIdx = 3'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 fall;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 stop_evt, can_load;

  // rx_prev_q tracks the synchronized line one cycle back for edge detection.
  always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
    if (RST_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
    if (RST_i) begin
      state_q     <= StIdle;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (Baud_rate_re_i) begin
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (Baud_rate_re_i) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LastIdx) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (Baud_rate_re_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // An ack in the stop-strobe cycle frees the holding register for the new byte.
  always_comb begin
    stop_evt = (state_q == StStop) & Baud_rate_re_i;
    can_load = ~valid_q | Rx_Ack_i;
    data_d   = data_q;
    valid_d  = valid_q;
    if (stop_evt && can_load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (Rx_Ack_i) begin
      valid_d = 1'b0;
    end
    frame_err_d = (frame_err_q & ~Err_Clr_i) | (stop_evt & ~rx_s_q);
    overrun_d   = (overrun_q & ~Err_Clr_i) | (stop_evt & ~can_load);
  end

  always_comb begin
    Clear_br_cnt_o = (state_q == StIdle) & fall;
    Rx_Busy_o      = (state_q != StIdle);
    Rx_Data_o      = data_q;
    Rx_Valid_o     = valid_q;
    Frame_Err_o    = frame_err_q;
    Overrun_o      = overrun_q;
  end

endmodule

// File: tb/tb_fcb_uart_rx.sv
// Bench for fcb_uart_rx: 8-bit and 5-bit instances, each with a divide-by-8 baud model,
// directed and random frames checked against a frame-level reference model.
module tb_fcb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx8, rx5, ack8, ack5, eclr8, eclr5;
  logic       baud8, baud5, clrc8, clrc5;
  logic [7:0] data8;
  logic [4:0] data5;
  logic       valid8, valid5, fe8, fe5, ov8, ov5, busy8, busy5;

  fcb_uart_rx #(.DATA_BITS(8)) u_dut8 (
    .Bus_Clk_i(clk), .RST_i(rst), .Rx_i(rx8), .Baud_rate_re_i(baud8),
    .Clear_br_cnt_o(clrc8), .Rx_Data_o(data8), .Rx_Valid_o(valid8), .Rx_Ack_i(ack8),
    .Frame_Err_o(fe8), .Overrun_o(ov8), .Err_Clr_i(eclr8), .Rx_Busy_o(busy8)
  );

  fcb_uart_rx #(.DATA_BITS(5)) u_dut5 (
    .Bus_Clk_i(clk), .RST_i(rst), .Rx_i(rx5), .Baud_rate_re_i(baud5),
    .Clear_br_cnt_o(clrc5), .Rx_Data_o(data5), .Rx_Valid_o(valid5), .Rx_Ack_i(ack5),
    .Frame_Err_o(fe5), .Overrun_o(ov5), .Err_Clr_i(eclr5), .Rx_Busy_o(busy5)
  );

  // Baud generator: 8-cycle bit period, mid-bit strobe, restarted by Clear_br_cnt_o.
  logic [2:0] bcnt8 = '0, bcnt5 = '0;
  int         npulse[2] = '{0, 0};
  assign baud8 = (bcnt8 == 3'd3);
  assign baud5 = (bcnt5 == 3'd3);
  always @(posedge clk) begin
    bcnt8 <= clrc8 ? 3'd0 : bcnt8 + 3'd1;
    bcnt5 <= clrc5 ? 3'd0 : bcnt5 + 3'd1;
    if (clrc8) npulse[0] <= npulse[0] + 1;
    if (clrc5) npulse[1] <= npulse[1] + 1;
  end

  // Reference model: holding register and sticky flags per instance.
  logic [7:0] m_data[2];
  bit         m_valid[2], m_fe[2], m_ov[2];
  int         n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx8 = v; else rx5 = v;
  endtask

  task automatic set_ack(input int d, input logic v);
    if (d == 0) ack8 = v; else ack5 = v;
  endtask

  task automatic set_eclr(input int d, input logic v);
    if (d == 0) eclr8 = v; else eclr5 = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = '0; m_valid[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
    end
  endtask

  task automatic check_outputs(input int d, input string tag, input bit exp_busy);
    if (d == 0) begin
      check_eq({tag, "_data8"}, 32'(data8), 32'(m_data[0]));
      check_eq({tag, "_valid8"}, 32'(valid8), 32'(m_valid[0]));
      check_eq({tag, "_fe8"}, 32'(fe8), 32'(m_fe[0]));
      check_eq({tag, "_ov8"}, 32'(ov8), 32'(m_ov[0]));
      check_eq({tag, "_busy8"}, 32'(busy8), 32'(exp_busy));
    end else begin
      check_eq({tag, "_data5"}, 32'(data5), 32'(m_data[1]));
      check_eq({tag, "_valid5"}, 32'(valid5), 32'(m_valid[1]));
      check_eq({tag, "_fe5"}, 32'(fe5), 32'(m_fe[1]));
      check_eq({tag, "_ov5"}, 32'(ov5), 32'(m_ov[1]));
      check_eq({tag, "_busy5"}, 32'(busy5), 32'(exp_busy));
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; optionally acks and/or clears errors in the stop-strobe cycle.
  task automatic send_frame(input int d, input logic [7:0] data, input logic stop,
                            input bit ack_stop, input bit clr_stop, input bit hold_low);
    int       nb = (d == 0) ? 8 : 5;
    int       p0 = npulse[d];
    bit       can;
    logic [7:0] mask = (d == 0) ? 8'hFF : 8'h1F;
    set_rx(d, 1'b0);
    wait_cycles(8);
    check_eq("busy_in_frame", 32'((d == 0) ? busy8 : busy5), 32'd1);
    for (int i = 0; i < nb; i++) begin
      set_rx(d, data[i]);
      wait_cycles(8);
    end
    set_rx(d, stop);
    wait_cycles(6);
    set_ack(d, ack_stop);
    set_eclr(d, clr_stop);
    check_eq("valid_before_stop", 32'((d == 0) ? valid8 : valid5), 32'(m_valid[d]));
    wait_cycles(1);
    set_ack(d, 1'b0);
    set_eclr(d, 1'b0);
    can = !m_valid[d] || ack_stop;
    if (clr_stop) begin m_fe[d] = 0; m_ov[d] = 0; end
    if (can) begin m_data[d] = data & mask; m_valid[d] = 1; end
    else m_ov[d] = 1;
    if (!stop) m_fe[d] = 1;
    check_outputs(d, "frame", 1'b0);
    check_eq("clr_pulses", 32'(npulse[d] - p0), 32'd1);
    wait_cycles(1);
    if (!stop && !hold_low) begin
      set_rx(d, 1'b1);
      wait_cycles(4);
    end
  endtask

  task automatic drive_raw(input logic [7:0] data);
    set_rx(0, 1'b0);
    wait_cycles(8);
    for (int i = 0; i < 8; i++) begin
      set_rx(0, data[i]);
      wait_cycles(8);
    end
    set_rx(0, 1'b1);
    wait_cycles(8);
  endtask

  task automatic do_ack(input int d);
    set_ack(d, 1'b1);
    wait_cycles(1);
    set_ack(d, 1'b0);
    m_valid[d] = 0;
  endtask

  task automatic do_err_clr(input int d);
    set_eclr(d, 1'b1);
    wait_cycles(1);
    set_eclr(d, 1'b0);
    m_fe[d] = 0;
    m_ov[d] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b1;
    rx8 = 1'b1; rx5 = 1'b1;
    ack8 = 1'b0; ack5 = 1'b0; eclr8 = 1'b0; eclr5 = 1'b0;
    model_reset();
    #1;
    check_outputs(0, "reset", 1'b0);
    check_outputs(1, "reset", 1'b0);
    check_eq("reset_clr8", 32'(clrc8), 32'd0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(4);

    send_frame(0, 8'hA5, 1'b1, 0, 0, 0);
    do_ack(0);
    check_outputs(0, "after_ack", 1'b0);

    send_frame(0, 8'h3C, 1'b0, 0, 0, 0);
    do_err_clr(0);
    check_outputs(0, "err_clr", 1'b0);
    do_ack(0);

    send_frame(0, 8'h11, 1'b1, 0, 0, 0);
    send_frame(0, 8'h22, 1'b1, 0, 0, 0);
    send_frame(0, 8'h33, 1'b1, 1, 0, 0);
    do_err_clr(0);
    do_ack(0);
    do_ack(0);
    check_outputs(0, "ack_empty", 1'b0);

    // Two-cycle low glitch: start sample sees high line.
    p0 = npulse[0];
    set_rx(0, 1'b0);
    wait_cycles(2);
    set_rx(0, 1'b1);
    wait_cycles(2);
    check_eq("glitch_busy", 32'(busy8), 32'd1);
    wait_cycles(14);
    check_outputs(0, "glitch", 1'b0);
    check_eq("glitch_pulses", 32'(npulse[0] - p0), 32'd1);

    // Framing error with simultaneous clear (set wins), then line held low.
    send_frame(0, 8'h81, 1'b0, 0, 1, 1);
    p0 = npulse[0];
    wait_cycles(24);
    check_eq("low_hold_pulses", 32'(npulse[0] - p0), 32'd0);
    check_outputs(0, "low_hold", 1'b0);
    set_rx(0, 1'b1);
    wait_cycles(4);
    do_err_clr(0);
    do_ack(0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] dat = 8'($urandom);
      logic       stp = ($urandom % 5) != 0;
      bit         ak = ($urandom % 4) == 0;
      bit         ec = ($urandom % 6) == 0;
      send_frame(0, dat, stp, ak, ec, 0);
      if ($urandom % 2) do_ack(0);
      if (($urandom % 4) == 0) do_err_clr(0);
      wait_cycles($urandom % 13);
    end

    // Reset during bit 4 of 0xFF, with the holding register full beforehand.
    send_frame(0, 8'hC3, 1'b1, 0, 0, 0);
    fork
      drive_raw(8'hFF);
      begin
        wait_cycles(44);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs(0, "rst_async", 1'b0);
        check_eq("rst_clrc8", 32'(clrc8), 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        p0 = npulse[0];
      end
    join
    check_outputs(0, "after_rst", 1'b0);
    check_eq("rst_pulses", 32'(npulse[0] - p0), 32'd0);
    send_frame(0, 8'h5A, 1'b1, 0, 0, 0);

    send_frame(1, 8'h15, 1'b1, 0, 0, 0);
    do_ack(1);
    for (int n = 0; n < 8; n++) begin
      send_frame(1, 8'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0, 0, 0);
      if ($urandom % 2) do_ack(1);
      if ($urandom % 2) do_err_clr(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
